// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the fifo_ctrl RAM front-end.
package fifo_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int FIFO_DEPTH     = 2**DEF_ADDR_WIDTH;
  localparam int DEF_AF_LEVEL   = 28;

  typedef logic [DEF_ADDR_WIDTH:0] occ_t;
endpackage

// File: rtl/fifo_ctrl_obuf.sv
// Two-entry output buffer that absorbs the RAM's registered read latency.
module fifo_ctrl_obuf
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_capture,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [0:1];
  logic                  r_wr;
  logic                  r_rd;
  logic [1:0]            r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_capture) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      case ({i_capture, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rd];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller in front of a registered-read dual-port RAM.
// Optional almost_full output is built when FIFO_CTRL_AFULL_EN is defined.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_CTRL_AFULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] r_wp;
  logic [ADDR_WIDTH-1:0] r_rp;
  logic [ADDR_WIDTH:0]   r_ram_words;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_inflight;
  logic [ADDR_WIDTH:0]   w_ram_words_nxt;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fetch;
  logic [1:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_full    = (r_count == FULL_CNT);
  assign in_ready  = !w_full && !rst;
  assign w_push    = in_valid && in_ready;
  assign out_valid = (w_occ != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // Keep buffered plus in-flight words at most two after this cycle's pop.
  assign w_fetch = (r_ram_words != '0) &&
                   (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign ram_we         = w_push;
  assign ram_write_addr = r_wp;
  assign ram_data       = in_data;
  assign ram_read_addr  = r_rp;

  assign count    = r_count;
  assign full     = w_full;
  assign empty    = (r_count == '0);
  assign out_data = w_head;

  always_comb begin
    w_ram_words_nxt = r_ram_words;
    w_count_nxt     = r_count;
    case ({w_push, w_fetch})
      2'b10:   w_ram_words_nxt = r_ram_words + CNT_ONE;
      2'b01:   w_ram_words_nxt = r_ram_words - CNT_ONE;
      default: w_ram_words_nxt = r_ram_words;
    endcase
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_ram_words <= '0;
      r_count     <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (w_push)  r_wp <= r_wp + ADDR_WIDTH'(1);
      if (w_fetch) r_rp <= r_rp + ADDR_WIDTH'(1);
      r_ram_words <= w_ram_words_nxt;
      r_count     <= w_count_nxt;
      r_inflight  <= w_fetch;
    end
  end

  fifo_ctrl_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .i_capture (r_inflight),
    .i_data    (ram_q),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_occ     (w_occ)
  );

`ifdef FIFO_CTRL_AFULL_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic r_afull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_afull <= 1'b0;
    else     r_afull <= (w_count_nxt >= AF_CNT);
  end

  assign almost_full = r_afull;
`endif

endmodule
